// File: rtl/fp_mul_pkg.sv
// Shared constants, FSM state type and IEEE-754 single-precision classifiers
// for the multiplier scheduler.
package fp_mul_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [FP_W-1:0]  QNAN     = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_ALL1 = 8'hFF;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;

  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == EXP_ALL1) && (x[FRAC_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == EXP_ALL1) && (x[FRAC_W-1:0] == '0);
  endfunction

  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return x[FP_W-2:0] == '0;
  endfunction

endpackage

// File: rtl/fp_mul_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping; returns one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Time-shares one external combinational fp32 multiplier among NREQ requesters
// with round-robin grants and tagged responses. FP_MUL_SCHED_FLAGS_EN adds resp_flags.
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [FP_W-1:0]      resp_data,
`ifdef FP_MUL_SCHED_FLAGS_EN
  output logic [1:0]           resp_flags,
`endif
  output logic [FP_W-1:0]      mul_a,
  output logic [FP_W-1:0]      mul_b,
  input  logic [FP_W-1:0]      mul_s
);

  sched_state_t    state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q;
  logic [FP_W-1:0] mul_a_q, mul_b_q, data_q, data_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any, accept;
  logic [FP_W-1:0] sel_a, sel_b;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  // The grantee is valid by construction, so a grant in IDLE is the handshake.
  assign accept = (state_q == IDLE) && gnt_any;
  assign sel_a  = req_a[int'(gnt_idx)*FP_W +: FP_W];
  assign sel_b  = req_b[int'(gnt_idx)*FP_W +: FP_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (int'(gnt_idx) == NREQ-1) rr_ptr_d = '0;
      else                         rr_ptr_d = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready  = grant;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef FP_MUL_SCHED_FLAGS_EN
  logic [1:0] flags_q, flags_d;

  always_comb begin
    flags_d[1] = is_nan(mul_a_q) || is_nan(mul_b_q) ||
                 (is_inf(mul_a_q) && is_zero(mul_b_q)) ||
                 (is_zero(mul_a_q) && is_inf(mul_b_q));
    flags_d[0] = is_inf(mul_s) && !is_inf(mul_a_q) && !is_inf(mul_b_q);
    data_d     = flags_d[1] ? QNAN : mul_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                flags_q <= '0;
    else if (state_q == EXEC)  flags_q <= flags_d;
  end

  assign resp_flags = flags_q;
`else
  assign data_d = mul_s;
`endif

  // Operands stay frozen outside IDLE so the multiplier output is stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
        id_q    <= gnt_idx;
      end
      if (state_q == EXEC) data_q <= data_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign resp_id   = id_q;
  assign resp_data = data_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched: transaction-level scoreboard model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_fp_mul_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*32-1:0]   req_a, req_b;
  logic                 resp_valid, resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [31:0]          resp_data, mul_a, mul_b, mul_s;
`ifdef FP_MUL_SCHED_FLAGS_EN
  logic [1:0]           resp_flags;
`endif

  always #5 clk = ~clk;

  fp_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
`ifdef FP_MUL_SCHED_FLAGS_EN
    .resp_flags (resp_flags),
`endif
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_s      (mul_s)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the shared multiplier: exact products for the directed vectors,
  // an arbitrary but deterministic mix otherwise.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'hC1CC0000, 32'hC1CAC000}: return 32'h44219100;
      {32'h40BC0000, 32'h3F180000}: return 32'h405F4000;
      {32'h3F800000, 32'h40000000}: return 32'h40000000;
      {32'h7F800000, 32'h00000000}: return 32'h7FC00000;
      {32'h7F800000, 32'h7F800000}: return 32'h7F800000;
      {32'h7F000000, 32'h7F000000}: return 32'h7F800000;
      {32'hFFC00001, 32'h3F800000}: return 32'hFFC00001;
      default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endcase
  endfunction

  always_comb mul_s = ref_mul(mul_a, mul_b);

  function automatic logic [1:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    logic an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    logic bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    logic ai = (a[30:0] == 31'h7F800000);
    logic bi = (b[30:0] == 31'h7F800000);
    logic si = (s[30:0] == 31'h7F800000);
    logic az = (a[30:0] == 0);
    logic bz = (b[30:0] == 0);
    return {an || bn || (ai && bz) || (az && bi), si && !ai && !bi};
  endfunction

  // Transaction model: one operation in flight; phase 0 = accepting,
  // 1 = computing, 2 = result offered.
  typedef struct {
    int          id;
    logic [31:0] d;
    logic [1:0]  f;
  } exp_t;

  exp_t        q[$];
  int          m_phase, m_ptr;
  logic [31:0] m_a, m_b;

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic exp_t mk_exp(input int g, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id = g;
    e.d  = ref_mul(a, b);
`ifdef FP_MUL_SCHED_FLAGS_EN
    e.f  = ref_flags(a, b, e.d);
    if (e.f[1]) e.d = 32'h7FC00000;
`else
    e.f  = 2'b00;
`endif
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_phase <= 0;
      m_ptr   <= 0;
      m_a     <= '0;
      m_b     <= '0;
    end else begin
      case (m_phase)
        0: if (pick(req_valid, m_ptr) >= 0) begin
             q.push_back(mk_exp(pick(req_valid, m_ptr),
                                req_a[32*pick(req_valid, m_ptr) +: 32],
                                req_b[32*pick(req_valid, m_ptr) +: 32]));
             m_a     <= req_a[32*pick(req_valid, m_ptr) +: 32];
             m_b     <= req_b[32*pick(req_valid, m_ptr) +: 32];
             m_ptr   <= (pick(req_valid, m_ptr) + 1) % NREQ;
             m_phase <= 1;
           end
        1: m_phase <= 2;
        default: if (resp_ready) begin
             q.pop_front();
             m_phase <= 0;
           end
      endcase
    end
  end

  function automatic logic [NREQ-1:0] exp_ready(input logic [NREQ-1:0] v, input int ptr, input int ph);
    if (ph != 0 || pick(v, ptr) < 0) return '0;
    return NREQ'(1) << pick(v, ptr);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_req_ready", 32'(req_ready), 32'(exp_ready(req_valid, m_ptr, m_phase)));
      chk("model_resp_valid", 32'(resp_valid), 32'(m_phase == 2));
      if (m_phase != 0) begin
        chk("model_mul_a", mul_a, m_a);
        chk("model_mul_b", mul_b, m_b);
      end
      if (m_phase == 2 && q.size() > 0) begin
        chk("model_resp_id", 32'(resp_id), q[0].id);
        chk("model_resp_data", resp_data, q[0].d);
`ifdef FP_MUL_SCHED_FLAGS_EN
        chk("model_resp_flags", 32'(resp_flags), 32'(q[0].f));
`endif
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_grant(input int i, input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(req_ready[i]), 32'd1);
  endtask

  task automatic wait_any(output int idx);
    int n = 0;
    idx = -1;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) idx = k;
  endtask

  // One isolated transaction with resp_ready high; returns at posedge+1 in IDLE.
  task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic [1:0] ef, input string name);
    @(posedge clk); #1;
    set_req(i, a, b);
    wait_grant(i, {name, "_grant"});
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk({name, "_exec_idle"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(resp_valid), 32'd1);
    chk({name, "_id"}, 32'(resp_id), i);
    chk({name, "_data"}, resp_data, ed);
`ifdef FP_MUL_SCHED_FLAGS_EN
    chk({name, "_flags"}, 32'(resp_flags), 32'(ef));
`else
    if (ef != 2'b00) chk({name, "_noflags"}, 32'(ef), 32'd0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({name, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({name, "_resp_data"}, resp_data, 32'd0);
    chk({name, "_mul_a"}, mul_a, 32'd0);
    chk({name, "_mul_b"}, mul_b, 32'd0);
`ifdef FP_MUL_SCHED_FLAGS_EN
    chk({name, "_resp_flags"}, 32'(resp_flags), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int g;

    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request from requester 0.
    run_one(0, 32'hC1CC0000, 32'hC1CAC000, 32'h44219100, 2'b00, "single");

    // Fresh pointer, all four requesters held valid.
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h3F000000 + i, 32'h40100000 + 7*i);
    set_req(2, 32'h40BC0000, 32'h3F180000);
    for (int k = 0; k < 5; k++) begin
      wait_any(g);
      chk("rr_order", g, order[k]);
      @(negedge clk);
      @(negedge clk);
      chk("rr_resp_valid", 32'(resp_valid), 32'd1);
      chk("rr_resp_id", 32'(resp_id), order[k]);
      if (order[k] == 2) chk("rr_req2_data", resp_data, 32'h405F4000);
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Back-pressure: requester 3 result held while requester 0 waits.
    resp_ready = 1'b0;
    set_req(3, 32'h3F800000, 32'h40000000);
    wait_grant(3, "bp_grant3");
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    set_req(0, 32'h12345678, 32'h0BADF00D);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_data, 32'h40000000);
      chk("bp_ready_zero", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while requester 1 is in EXEC.
    set_req(1, 32'h40400000, 32'h40A00000);
    wait_grant(1, "rst_grant1");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("rst_exec");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    run_one(3, 32'h3F800000, 32'h40000000, 32'h40000000, 2'b00, "post_rst");

    // Pointer wrap and skip: grant 2 leaves ptr=3, then only requester 1.
    run_one(2, 32'h40BC0000, 32'h3F180000, 32'h405F4000, 2'b00, "ptr_to3");
    run_one(1, 32'hC1CC0000, 32'hC1CAC000, 32'h44219100, 2'b00, "wrap_skip");
    @(posedge clk); #1;
    set_req(1, 32'h1, 32'h2);
    set_req(2, 32'h3, 32'h4);
    set_req(3, 32'h5, 32'h6);
    wait_any(g);
    chk("ptr_is2", g, 2);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    // Special values through the shared multiplier.
`ifdef FP_MUL_SCHED_FLAGS_EN
    run_one(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 2'b10, "inf_x_zero");
    run_one(0, 32'h7F800000, 32'h7F800000, 32'h7F800000, 2'b00, "inf_x_inf");
    run_one(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 2'b01, "overflow");
    run_one(0, 32'hFFC00001, 32'h3F800000, 32'h7FC00000, 2'b10, "nan_in");
`else
    run_one(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 2'b00, "inf_x_zero");
    run_one(0, 32'h7F800000, 32'h7F800000, 32'h7F800000, 2'b00, "inf_x_inf");
    run_one(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 2'b00, "overflow");
    run_one(0, 32'hFFC00001, 32'h3F800000, 32'hFFC00001, 2'b00, "nan_in");
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
